// File: rtl/keypad_pkg.sv
// Shared types and key-code helpers for the 4x4 keypad matrix emulator.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRESS = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam int ROW_MSB = 7;
  localparam int ROW_LSB = 4;
  localparam int COL_MSB = 3;
  localparam int COL_LSB = 0;

  localparam logic [7:0] KEY_NONE = 8'h00;

  // A usable code selects exactly one row and exactly one column.
  function automatic logic keypad_code_valid(input logic [7:0] code);
    return $onehot(code[ROW_MSB:ROW_LSB]) && $onehot(code[COL_MSB:COL_LSB]);
  endfunction

endpackage

// File: rtl/keypad_col_resp.sv
// Registered column response: drives a column low when the scanner strobes the row of the held key.
module keypad_col_resp
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  input  logic [7:0] code,
  input  logic       pressed,
  output logic [3:0] col
);

  logic       row_hit;
  logic [3:0] hit;

  // Code bit [7-r] names row r and bit [3-c] names column c; any strobed row of the key counts.
  always_comb begin
    row_hit = 1'b0;
    hit     = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      row_hit = row_hit | (~row[r] & code[ROW_MSB - r]);
    end
    for (int c = 0; c < 4; c++) begin
      hit[c] = pressed & row_hit & code[COL_MSB - c];
    end
  end

  // Active-low column register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= 4'b1111;
    end else begin
      col <= ~hit;
    end
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Keypad responder: accepts key requests, holds each pressed then released, answers row strobes.
// Optional contact bounce at press start is enabled with `define KEYPAD_EMU_BOUNCE_EN.
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 200,
  parameter int GAP_CYCLES    = 100,
  parameter int BOUNCE_CYCLES = 32,
  parameter int BOUNCE_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       busy,
  output logic       pressed,
  output logic       done,
  output logic       err
);

  localparam int HG_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (HG_MAX > BOUNCE_CYCLES) ? HG_MAX : BOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_PERIOD < 1) begin : g_param_check
    $error("keypad_matrix_emulator: cycle parameters must be >= 1");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       code;
  logic             next_contact;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int PH_W = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
  logic [CNT_W-1:0] el;
  logic [CNT_W-1:0] el_next;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_next;

  // el is the current press cycle index (saturating at the window end); phase times each toggle.
  always_comb begin
    next_contact = 1'b1;
    el_next      = el;
    phase_next   = phase;
    if (int'(el) + 1 >= BOUNCE_CYCLES) begin
      next_contact = 1'b1;
    end else begin
      el_next = el + CNT_ONE;
      if (int'(phase) == BOUNCE_PERIOD - 1) begin
        next_contact = ~pressed;
        phase_next   = {PH_W{1'b0}};
      end else begin
        next_contact = pressed;
        phase_next   = phase + PH_W'(1);
      end
    end
  end
`else
  assign next_contact = 1'b1;
`endif

  // Request handshake and press/gap sequencing with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= CNT_ZERO;
      code      <= KEY_NONE;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      pressed   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      el        <= CNT_ZERO;
      phase     <= {PH_W{1'b0}};
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid && keypad_code_valid(key_code)) begin
            code      <= key_code;
            cnt       <= HOLD_LOAD;
            state     <= PRESS;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            pressed   <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            el        <= CNT_ZERO;
            phase     <= {PH_W{1'b0}};
`endif
          end else if (key_valid) begin
            err <= 1'b1;
          end else begin
            err <= 1'b0;
          end
        end
        PRESS: begin
          if (cnt == CNT_ZERO) begin
            cnt     <= GAP_LOAD;
            state   <= GAP;
            pressed <= 1'b0;
            done    <= (GAP_CYCLES == 1);
          end else begin
            cnt     <= cnt - CNT_ONE;
            pressed <= next_contact;
`ifdef KEYPAD_EMU_BOUNCE_EN
            el      <= el_next;
            phase   <= phase_next;
`endif
          end
        end
        GAP: begin
          // done is raised for the final gap cycle so key_ready follows it.
          if (cnt == CNT_ZERO) begin
            state     <= IDLE;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt  <= cnt - CNT_ONE;
            done <= (cnt == CNT_ONE);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= CNT_ZERO;
          key_ready <= 1'b1;
          busy      <= 1'b0;
          pressed   <= 1'b0;
        end
      endcase
    end
  end

  keypad_col_resp u_col_resp (
    .clk     (clk),
    .rst     (rst),
    .row     (row),
    .code    (code),
    .pressed (pressed),
    .col     (col)
  );

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Self-checking bench: a long-hold instance for timing/scanner checks, a short one for tables and random traffic.
module tb_keypad_matrix_emulator;

  localparam int B_HOLD = 200, B_GAP = 100, B_BC = 16, B_BP = 4;
  localparam int S_HOLD = 5,   S_GAP = 3,   S_BC = 32, S_BP = 4;

  logic clk = 1'b0;
  logic rst;
  logic       b_valid, b_ready, b_busy, b_pressed, b_done, b_err;
  logic [7:0] b_code;
  logic [3:0] b_row, b_col;
  logic       s_valid, s_ready, s_busy, s_pressed, s_done, s_err;
  logic [7:0] s_code;
  logic [3:0] s_row, s_col;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_matrix_emulator #(.HOLD_CYCLES(B_HOLD), .GAP_CYCLES(B_GAP),
                           .BOUNCE_CYCLES(B_BC), .BOUNCE_PERIOD(B_BP)) dut_b (
    .clk(clk), .rst(rst), .key_valid(b_valid), .key_ready(b_ready), .key_code(b_code),
    .row(b_row), .col(b_col), .busy(b_busy), .pressed(b_pressed), .done(b_done), .err(b_err));

  keypad_matrix_emulator #(.HOLD_CYCLES(S_HOLD), .GAP_CYCLES(S_GAP),
                           .BOUNCE_CYCLES(S_BC), .BOUNCE_PERIOD(S_BP)) dut_s (
    .clk(clk), .rst(rst), .key_valid(s_valid), .key_ready(s_ready), .key_code(s_code),
    .row(s_row), .col(s_col), .busy(s_busy), .pressed(s_pressed), .done(s_done), .err(s_err));

  typedef struct {
    logic [7:0] code;
    logic [3:0] row;
    logic       exp_err;
    logic [3:0] exp_col;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout at %0t", name, $time);
  endtask

  // Contact state at press cycle e, straight from the bounce rule.
  function automatic logic contact(input int e, input int bc, input int bp);
`ifdef KEYPAD_EMU_BOUNCE_EN
    return (e >= bc) || (((e / bp) % 2) == 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic code_ok(input logic [7:0] c);
    return ($countones(c[7:4]) == 1) && ($countones(c[3:0]) == 1);
  endfunction

  function automatic logic [3:0] col_model(input logic p, input logic [7:0] c, input logic [3:0] r);
    logic [3:0] res;
    res = 4'b1111;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (p && !r[ri] && c[7 - ri] && c[3 - ci]) res[ci] = 1'b0;
    return res;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] c);
    int n = 0;
    while (!b_ready && n < 1000) begin tick(); n++; end
    if (!b_ready) timeout("send_b");
    b_valid = 1'b1;
    b_code  = c;
    tick();
    b_valid = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] c);
    int n = 0;
    while (!s_ready && n < 100) begin tick(); n++; end
    if (!s_ready) timeout("send_s");
    s_valid = 1'b1;
    s_code  = c;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_b_ready;
    int n = 0;
    while (!b_ready && n < 1000) begin tick(); n++; end
    if (!b_ready) timeout("wait_b_ready");
  endtask

  task automatic wait_s_ready;
    int n = 0;
    while (!s_ready && n < 100) begin tick(); n++; end
    if (!s_ready) timeout("wait_s_ready");
  endtask

  // Scanner model: strobe each row for 10 cycles and decode the low column seen.
  task automatic scan_b(output logic [7:0] got);
    got = 8'h00;
    for (int r = 0; r < 4; r++) begin
      b_row = ~(4'b0001 << r);
      repeat (10) tick();
      for (int c = 0; c < 4; c++)
        if (!b_col[c]) begin got[7 - r] = 1'b1; got[3 - c] = 1'b1; end
    end
    b_row = 4'b1111;
  endtask

  initial begin
    vec_t vt[10];
    logic [7:0] got;
    int low, dones, done_e, n;

    vt[0] = '{8'h88, 4'b1110, 1'b0, 4'b1110};
    vt[1] = '{8'h88, 4'b1101, 1'b0, 4'b1111};
    vt[2] = '{8'h11, 4'b0111, 1'b0, 4'b0111};
    vt[3] = '{8'h48, 4'b1101, 1'b0, 4'b1110};
    vt[4] = '{8'h24, 4'b1011, 1'b0, 4'b1101};
    vt[5] = '{8'h81, 4'b0000, 1'b0, 4'b0111};
    vt[6] = '{8'h8C, 4'b1110, 1'b1, 4'b1111};
    vt[7] = '{8'h00, 4'b0000, 1'b1, 4'b1111};
    vt[8] = '{8'h18, 4'b0111, 1'b0, 4'b1110};
    vt[9] = '{8'h42, 4'b1111, 1'b0, 4'b1111};

    rst = 1'b1;
    b_valid = 1'b0; b_code = 8'h00; b_row = 4'b1111;
    s_valid = 1'b0; s_code = 8'h00; s_row = 4'b1111;
    repeat (3) tick();
    check("reset_b", {b_col, b_ready, b_busy, b_pressed, b_done, b_err}, {4'b1111, 5'b10000});
    check("reset_s", {s_col, s_ready, s_busy, s_pressed, s_done, s_err}, {4'b1111, 5'b10000});
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Long press of 8'h88: per-cycle status against the press/gap timeline, plus row response.
    b_row = 4'b1110;
    send_b(8'h88);
    for (int e = 0; e <= B_HOLD + B_GAP + 2; e++) begin
      check("b_timeline", {b_ready, b_busy, b_pressed, b_done},
            {!(e < B_HOLD + B_GAP), (e < B_HOLD + B_GAP),
             (e < B_HOLD) && contact(e, B_BC, B_BP), (e == B_HOLD + B_GAP - 1)});
      if (e == 1) begin
        check("b_col_row0", b_col, contact(0, B_BC, B_BP) ? 4'b1110 : 4'b1111);
        b_row = 4'b1101;
      end
      if (e == 2) begin
        check("b_col_row1", b_col, 4'b1111);
        b_row = 4'b1110;
      end
      tick();
    end
    b_row = 4'b1111;

    // Short press of 8'h11: ready low for HOLD+GAP cycles, one done on the last of them.
    send_s(8'h11);
    low = 1; dones = s_done; done_e = s_done ? 0 : -1; n = 0;
    while (n < 50) begin
      tick();
      n++;
      if (s_ready) break;
      if (s_done) done_e = low;
      dones += s_done;
      low++;
    end
    check("s_ready_low", 16'(low), 16'(S_HOLD + S_GAP));
    check("s_done_count", 16'(dones), 16'd1);
    check("s_done_pos", 16'(done_e), 16'(S_HOLD + S_GAP - 1));

    // Table of codes and row strobes.
    for (int i = 0; i < 10; i++) begin
      wait_s_ready();
      s_row = vt[i].row;
      send_s(vt[i].code);
      check($sformatf("tbl%0d_err_busy", i), {s_err, s_busy}, {vt[i].exp_err, !vt[i].exp_err});
      tick();
      check($sformatf("tbl%0d_col", i), s_col, vt[i].exp_col);
    end
    wait_s_ready();

    // Invalid code leaves the emulator idle and silent on every row pattern.
    send_s(8'h8C);
    check("inv_err", {s_err, s_busy}, 2'b10);
    for (int r = 0; r < 5; r++) begin
      s_row = (r == 4) ? 4'b0000 : ~(4'b0001 << r);
      tick();
      check("inv_idle", {s_busy, s_err, s_col}, {2'b00, 4'b1111});
    end
    s_row = 4'b1111;

    // Back-to-back requests held valid; second accepted only after done, scanner decodes both.
    wait_b_ready();
    b_valid = 1'b1; b_code = 8'h48;
    tick();
    b_code = 8'h24;
    repeat (40) tick();
    scan_b(got);
    check("scan_first", got, 8'h48);
    n = 0;
    while (!b_done && n < 400) begin tick(); n++; end
    if (!b_done) timeout("b2b_done");
    tick();
    check("b2b_ready_after_done", {b_ready, b_busy}, 2'b10);
    tick();
    check("b2b_accepted", {b_ready, b_busy, b_pressed}, 3'b011);
    b_valid = 1'b0;
    repeat (40) tick();
    scan_b(got);
    check("scan_second", got, 8'h24);
    wait_b_ready();

    // Reset mid-press forces columns high at once and drops the request.
    b_row = 4'b1110;
    send_b(8'h88);
    repeat (3) tick();
    check("pre_rst_col", b_col, 4'b1110);
    rst = 1'b1;
    #1;
    check("rst_async", {b_col, b_ready, b_busy, b_pressed}, {4'b1111, 3'b100});
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_rst_idle", {b_col, b_busy, b_pressed}, {4'b1111, 2'b00});
    end
    b_row = 4'b1111;

    // Random traffic on the short instance against a timeline model.
    wait_s_ready();
    tick();
    begin
      int start = -1, e;
      logic [7:0] cm = 8'h00, pc = 8'h00, t;
      logic [3:0] pr = 4'b1111, ecol;
      logic rdy_p = 1'b1, prs_p = 1'b0, pv = 1'b0;
      logic ebusy, eprs, edone, eerr;
      s_row = 4'b1111;
      for (int it = 0; it < 1500; it++) begin
        tick();
        ecol = col_model(prs_p, cm, pr);
        eerr = 1'b0;
        if (rdy_p && pv) begin
          if (code_ok(pc)) begin start = it; cm = pc; end
          else eerr = 1'b1;
        end
        e = it - start;
        if (start >= 0 && e >= S_HOLD + S_GAP) start = -1;
        ebusy = (start >= 0);
        eprs  = ebusy && (e < S_HOLD) && contact(e, S_BC, S_BP);
        edone = ebusy && (e == S_HOLD + S_GAP - 1);
        check("random", {s_ready, s_busy, s_pressed, s_done, s_err, s_col},
              {!ebusy, ebusy, eprs, edone, eerr, ecol});
        rdy_p = !ebusy;
        prs_p = eprs;
        pv = ($urandom % 3) == 0;
        if (($urandom % 4) == 0) begin
          pc = 8'($urandom);
        end else begin
          t  = 8'h80 >> $urandom_range(3, 0);
          pc = t | (8'h08 >> $urandom_range(3, 0));
        end
        case ($urandom % 3)
          0:       pr = 4'b1111;
          1:       pr = ~(4'b0001 << $urandom_range(3, 0));
          default: pr = 4'($urandom);
        endcase
        s_valid = pv; s_code = pc; s_row = pr;
      end
      s_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
